// File: rtl/req_ack_2ph_tx_buf.sv
// Buffered 2-phase (toggle) req/ack CDC transmitter: val/rdy FIFO front end,
// one word in flight at a time, ack synchroniser, timeout and spurious-ack flags.
module req_ack_2ph_tx_buf #(
    parameter int DW          = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 64
) (
    input  logic                         clk_tx,
    input  logic                         rst_b,
    input  logic                         val,
    input  logic [DW-1:0]                din,
    output logic                         rdy,
    input  logic                         ack,
    output logic                         req,
    output logic [DW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    input  logic                         err_clr,
    output logic                         err_timeout,
    output logic                         err_spur
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH+1);
    localparam int CW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES+1) : 1;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_ACK = 1'b1;

    logic [DW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_d;
    logic                   ack_evt;
    logic [0:0]             state;
    logic [CW-1:0]          to_cnt;
    logic                   push;
    logic                   pop;
    logic                   spur_hit;
    logic                   to_hit;

    // rdy depends only on registered occupancy, never on val or ack
    assign rdy      = (fill < FW'(DEPTH));
    assign push     = val && rdy;
    assign ack_evt  = ack_sync[SYNC_STAGES-1] ^ ack_d;
    assign pop      = (fill != '0) && ((state == S_IDLE) || ack_evt);
    assign spur_hit = (state == S_IDLE) && ack_evt;
    assign to_hit   = (TO_CYCLES != 0) && (state == S_WAIT_ACK) && !ack_evt &&
                      (to_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            ack_sync <= '0;
            ack_d    <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
            ack_d    <= ack_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_tx) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            state  <= S_IDLE;
            req    <= 1'b0;
            dout   <= '0;
            to_cnt <= '0;
        end else if (pop) begin
            state  <= S_WAIT_ACK;
            req    <= ~req;
            dout   <= mem[rd_ptr];
            to_cnt <= '0;
        end else if (state == S_WAIT_ACK) begin
            if (ack_evt) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else if (to_cnt != CW'(TO_CYCLES)) begin
                to_cnt <= to_cnt + CW'(1);
            end
        end
    end

    // a set condition in the same cycle as err_clr takes priority
    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            err_timeout <= 1'b0;
            err_spur    <= 1'b0;
        end else begin
            if (to_hit)       err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            if (spur_hit)     err_spur    <= 1'b1;
            else if (err_clr) err_spur    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_req_ack_2ph_tx_buf.sv
// Self-checking bench for req_ack_2ph_tx_buf: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, random phase.
module tb_req_ack_2ph_tx_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TO    = 64;

    logic          clk_tx = 1'b0;
    logic          rst_b  = 1'b1;
    logic          val    = 1'b0;
    logic [DW-1:0] din    = '0;
    logic          rdy;
    logic          ack    = 1'b0;
    logic          req;
    logic [DW-1:0] dout;
    logic [2:0]    fill;
    logic          err_clr = 1'b0;
    logic          err_timeout;
    logic          err_spur;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    req_ack_2ph_tx_buf #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TO_CYCLES(TO)) dut (
        .clk_tx(clk_tx), .rst_b(rst_b), .val(val), .din(din), .rdy(rdy),
        .ack(ack), .req(req), .dout(dout), .fill(fill), .err_clr(err_clr),
        .err_timeout(err_timeout), .err_spur(err_spur)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference model: FIFO as a queue, one transfer in flight, ack seen SS+1 edges late
    logic [DW-1:0] mq[$];
    bit            m_busy = 0;
    bit            m_req  = 0;
    logic [DW-1:0] m_dout = '0;
    int            m_wc   = 0;
    bit            m_eto  = 0;
    bit            m_esp  = 0;
    bit            h[SS+1];

    always @(posedge clk_tx) begin
        bit evt, do_push, do_pop, set_to, set_sp;
        int sz;
        if (!rst_b) begin
            mq.delete();
            m_busy = 0; m_req = 0; m_dout = '0; m_wc = 0; m_eto = 0; m_esp = 0;
            for (int i = 0; i <= SS; i++) h[i] = 0;
        end else begin
            evt     = h[SS-1] ^ h[SS];
            sz      = mq.size();
            do_push = val && (sz < DEPTH);
            do_pop  = (sz > 0) && (!m_busy || evt);
            set_sp  = !m_busy && evt;
            set_to  = 0;
            if (m_busy && !evt && m_wc < TO) begin
                m_wc++;
                if (m_wc == TO) set_to = 1;
            end
            m_eto = set_to ? 1'b1 : (err_clr ? 1'b0 : m_eto);
            m_esp = set_sp ? 1'b1 : (err_clr ? 1'b0 : m_esp);
            if (do_pop) begin
                m_dout = mq.pop_front();
                m_req  = !m_req;
                m_busy = 1;
                m_wc   = 0;
            end else if (m_busy && evt) begin
                m_busy = 0;
                m_wc   = 0;
            end
            if (do_push) mq.push_back(din);
            for (int i = SS; i > 0; i--) h[i] = h[i-1];
            h[0] = ack;
        end
    end

    always @(negedge clk_tx) begin
        if (run_cmp && rst_b) begin
            chk("req",         {31'd0, req},         {31'd0, m_req});
            chk("dout",        {16'd0, dout},        {16'd0, m_dout});
            chk("fill",        {29'd0, fill},        mq.size());
            chk("rdy",         {31'd0, rdy},         {31'd0, (mq.size() < DEPTH)});
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_eto});
            chk("err_spur",    {31'd0, err_spur},    {31'd0, m_esp});
        end
    end

    task automatic tick;
        @(posedge clk_tx);
        #1;
    endtask

    initial begin
        int cd;
        #1 rst_b = 1'b0;
        #1;
        chk("rst_req",  {31'd0, req},         32'd0);
        chk("rst_dout", {16'd0, dout},        32'd0);
        chk("rst_fill", {29'd0, fill},        32'd0);
        chk("rst_rdy",  {31'd0, rdy},         32'd1);
        chk("rst_eto",  {31'd0, err_timeout}, 32'd0);
        chk("rst_esp",  {31'd0, err_spur},    32'd0);
        tick; tick;
        rst_b   = 1'b1;
        run_cmp = 1'b1;

        // single transfer
        val = 1'b1; din = 16'hA5A5;
        tick;
        val = 1'b0;
        chk("single_fill_acc", {29'd0, fill}, 32'd1);
        chk("single_req_pre",  {31'd0, req},  32'd0);
        tick;
        chk("single_req",  {31'd0, req},  32'd1);
        chk("single_dout", {16'd0, dout}, 32'hA5A5);
        chk("single_fill", {29'd0, fill}, 32'd0);
        ack = 1'b1;
        repeat (4) tick;

        // fill and backpressure
        for (int k = 1; k <= 8; k++) begin
            val = 1'b1; din = DW'(k);
            tick;
        end
        val = 1'b0;
        chk("bp_fill", {29'd0, fill}, 32'd4);
        chk("bp_rdy",  {31'd0, rdy},  32'd0);
        chk("bp_dout", {16'd0, dout}, 32'h0001);
        chk("bp_req",  {31'd0, req},  32'd0);

        // back-to-back launch on each ack
        ack = ~ack;
        repeat (3) tick;
        chk("b2b_req",  {31'd0, req},  32'd1);
        chk("b2b_dout", {16'd0, dout}, 32'h0002);
        chk("b2b_fill", {29'd0, fill}, 32'd3);
        chk("b2b_rdy",  {31'd0, rdy},  32'd1);
        for (int k = 3; k <= 5; k++) begin
            ack = ~ack;
            repeat (3) tick;
            chk("b2b_dout_k", {16'd0, dout}, k);
            chk("b2b_fill_k", {29'd0, fill}, 5 - k);
        end
        ack = ~ack;
        repeat (4) tick;
        chk("b2b_end_fill", {29'd0, fill}, 32'd0);
        chk("b2b_end_req",  {31'd0, req},  32'd0);
        chk("b2b_end_dout", {16'd0, dout}, 32'h0005);

        // timeout
        val = 1'b1; din = 16'h1234;
        tick;
        val = 1'b0;
        tick;
        chk("to_launch", {16'd0, dout}, 32'h1234);
        repeat (TO - 1) tick;
        chk("to_before", {31'd0, err_timeout}, 32'd0);
        tick;
        chk("to_set", {31'd0, err_timeout}, 32'd1);
        ack = ~ack;
        repeat (4) tick;
        chk("to_late_sticky", {31'd0, err_timeout}, 32'd1);
        chk("to_late_fill",   {29'd0, fill},        32'd0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("to_clr", {31'd0, err_timeout}, 32'd0);

        // spurious ack in IDLE
        ack = ~ack;
        tick; tick;
        chk("spur_early", {31'd0, err_spur}, 32'd0);
        tick;
        chk("spur_set",  {31'd0, err_spur}, 32'd1);
        chk("spur_req",  {31'd0, req},      32'd1);
        chk("spur_fill", {29'd0, fill},     32'd0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("spur_clr", {31'd0, err_spur}, 32'd0);

        // reset in WAIT_ACK with three words buffered
        for (int k = 0; k < 4; k++) begin
            val = 1'b1; din = DW'(16'h0011 + k);
            tick;
        end
        val = 1'b0;
        chk("mid_fill", {29'd0, fill}, 32'd3);
        rst_b = 1'b0; ack = 1'b0;
        #1;
        chk("mid_rst_req",  {31'd0, req},  32'd0);
        chk("mid_rst_dout", {16'd0, dout}, 32'd0);
        chk("mid_rst_fill", {29'd0, fill}, 32'd0);
        chk("mid_rst_rdy",  {31'd0, rdy},  32'd1);
        chk("mid_rst_err",  {30'd0, err_timeout, err_spur}, 32'd0);
        tick; tick;
        rst_b = 1'b1;
        val = 1'b1; din = 16'hBEEF;
        tick;
        val = 1'b0;
        tick;
        chk("post_rst_req",  {31'd0, req},  32'd1);
        chk("post_rst_dout", {16'd0, dout}, 32'hBEEF);
        ack = 1'b1;
        repeat (4) tick;

        // randomized traffic against the model
        cd = -1;
        for (int i = 0; i < 3000; i++) begin
            val     = 1'($urandom_range(0, 1));
            din     = DW'($urandom);
            err_clr = ($urandom_range(0, 63) == 0);
            if (req != ack) begin
                if (cd < 0)       cd = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 90) : $urandom_range(0, 6);
                else if (cd == 0) begin ack = ~ack; cd = -1; end
                else              cd--;
            end else begin
                cd = -1;
                if ($urandom_range(0, 299) == 0) ack = ~ack;
            end
            if (i == 1500) begin
                rst_b = 1'b0; ack = 1'b0; val = 1'b0; cd = -1;
                tick; tick;
                rst_b = 1'b1;
            end
            tick;
        end
        val = 1'b0; err_clr = 1'b0;
        repeat (4) tick;
        run_cmp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_ack_2ph_tx_buf.md
Name: req_ack_2ph_tx_buf

Overview:
- Buffered, parametrised successor to the single-word 2-phase (toggle) req/ack CDC transmitter.
- Accepts words in the clk_tx domain through a val/rdy handshake and stores them in a DEPTH-entry FIFO.
- Launches one word at a time across the clock boundary by toggling req with dout held stable.
- Adds back-to-back launch on ack, configurable synchroniser depth, an ack timeout monitor, and spurious-ack detection.

Parameters:
- DW, 16: data width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2: ack synchroniser flops; range 2..4.
- TO_CYCLES, 64: WAIT_ACK cycles before err_timeout is set; 0 disables the timeout.

Ports:
- clk_tx  in  1  transmit-domain clock.
- rst_b  in  1  reset, asynchronous, active-low.
- val  in  1  producer has a valid word.
- din  in  DW  producer data.
- rdy  out  1  FIFO can accept a word.
- ack  in  1  2-phase ack toggle from the receiver domain (asynchronous).
- req  out  1  2-phase request toggle.
- dout  out  DW  data to receiver; stable from a req toggle until the next req toggle.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- err_clr  in  1  synchronous clear of the error flags.
- err_timeout  out  1  sticky: ack not seen within TO_CYCLES.
- err_spur  out  1  sticky: ack toggle seen while in IDLE.

Behaviour:
- Reset values (rst_b low, asynchronous): req=0, dout=0, rdy=1, fill=0, err_timeout=0, err_spur=0. Synchroniser flops, edge-detect flop and timeout counter all clear to 0. FSM enters IDLE.
- Reset mid-operation discards FIFO contents and the in-flight word. The receiver must be reset in the same reset event so both toggle phases restart at 0.
- Accept: a word is written when val && rdy at a rising edge.
- rdy = (fill < DEPTH), decoded from registered state only. No combinational path from val or ack to rdy.
- ack synchroniser: SYNC_STAGES flops plus one edge-detect flop. ack_evt = XOR of the last sync flop and the edge-detect flop.
- ack_evt is acted on at the (SYNC_STAGES+1)th rising edge after the ack toggle settles.
- FSM state IDLE:
  - If fill>0 at an edge: pop the head into dout, toggle req, go to WAIT_ACK.
  - A word accepted at edge N into an empty FIFO launches at edge N+1.
  - ack_evt in IDLE: set err_spur; req and FIFO are unaffected.
- FSM state WAIT_ACK:
  - On ack_evt with fill>0: pop the next word into dout and toggle req at the same edge. Stay in WAIT_ACK and restart the timeout count.
  - On ack_evt with fill=0: go to IDLE; dout holds its last value.
  - Timeout counter increments each WAIT_ACK cycle and saturates. err_timeout is set when the count reaches TO_CYCLES.
  - No retransmit on timeout; a late ack still completes the transfer normally.
- Simultaneous push and pop: fill is unchanged.
- When full, rdy=0 even if a pop occurs in the same cycle. rdy rises one edge after the pop.
- FIFO pointers wrap modulo DEPTH. fill counts 0..DEPTH inclusive.
- err_clr clears both error flags. If a set condition occurs in the same cycle, the set wins.
- dout changes only at the edge where req toggles (or at reset).

Test Plan (DW=16, DEPTH=4, SYNC_STAGES=2, TO_CYCLES=64):
- Single transfer: push 0xA5A5 at edge N into idle → edge N+1: req 0→1, dout=0xA5A5, fill=0. Toggle ack → FSM returns to IDLE at the 3rd edge after the toggle.
- Fill and backpressure: ack held constant; val=1 for 8 cycles with data 1..8 → word 1 launched, words 2..5 buffered, fill=4, rdy=0. Words 6..8 are not accepted; dout stays 0x0001.
- Back-to-back launch: from the previous state, toggle ack → at the ack_evt edge req toggles, dout=0x0002, fill=3, and rdy=1 one edge later. Repeat ack toggles → 3,4,5 delivered in order, then IDLE.
- Timeout: launch 0x1234 and withhold ack → err_timeout=1 on the 64th WAIT_ACK cycle. Late ack → IDLE, err_timeout stays 1. Pulse err_clr → err_timeout=0.
- Spurious ack: in IDLE with fill=0, toggle ack → err_spur=1 three edges later; req and fill unchanged.
- Reset mid-operation: in WAIT_ACK with fill=3, assert rst_b=0 asynchronously → req=0, dout=0, fill=0, rdy=1, errors 0 immediately. After release, push 0xBEEF → req 0→1.
